pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Output-side counterpart to the input debouncer. The debouncer rejects short events; this block lengthens them.
- A single-cycle trigger drives a clean, minimum-length output pulse (LED, buzzer, scope pin). A mandatory low gap follows each pulse so consecutive events stay visually distinct.
- Timing is tick-based: an internal prescaler generates the tick (10 ms at 100 MHz by default), and hold/gap lengths are counted in ticks.
- Sits between control FSMs (e.g. debounced-button logic) and board output pins.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per tick; must be >= 2.
- HOLD_TICKS, 10, output-high duration in ticks; must be >= 1.
- GAP_TICKS, 5, minimum output-low duration after each pulse, in ticks; 0 means no gap.
- RETRIGGER, 1, 1 = a trigger during HOLD restarts the hold; 0 = the trigger is queued as pending.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- trig_in  in  1  event request, sampled every rising edge; a level held high acts as a trigger on every cycle.
- Q_out  out  1  stretched pulse, registered.
- busy  out  1  high in HOLD or GAP.
- pending  out  1  one queued trigger is waiting.
- miss  out  1  one-cycle pulse: trigger dropped because the queue was already full.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prescaler=0, tick count=0. Q_out=0, busy=0, pending=0, miss=0.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick when the count equals TICK_DIV-1. It clears to 0 on every state entry and on every hold restart, so durations are exact.
- States are IDLE, HOLD and GAP, encoded as a 2-bit register.
- IDLE:
  - trig_in=1 at edge n moves to HOLD; Q_out=1 from edge n (one-edge latency).
  - Otherwise stay; Q_out=0.
- HOLD:
  - Q_out=1, busy=1.
  - Leave after exactly HOLD_TICKS*TICK_DIV cycles.
  - Exit goes to GAP if GAP_TICKS>0.
  - If GAP_TICKS=0: go to HOLD again with fresh counters if pending=1, clearing pending (Q_out stays 1, no low cycle); otherwise go to IDLE.
- Trigger while in HOLD:
  - RETRIGGER=1: restart prescaler and tick count; no pending set.
  - RETRIGGER=0: set pending if clear; if pending is already set, pulse miss.
- GAP:
  - Q_out=0, busy=1.
  - A trigger sets pending, or pulses miss if pending is already set.
  - After exactly GAP_TICKS*TICK_DIV cycles: go to HOLD if pending (clear pending), otherwise IDLE.
- Simultaneous events: a trigger on the final cycle of HOLD/GAP counts as arriving in that state and is queued before the transition.
  - A trigger on the final HOLD cycle with RETRIGGER=1 restarts HOLD; the restart wins over the exit.
- Queue depth is 1; pending is a single flag, never a counter.
- Widths:
  - Prescaler width = $clog2(TICK_DIV).
  - Tick counter width = $clog2(max(HOLD_TICKS, GAP_TICKS)+1).
  - No wrap is permitted: counters clear on state change.
- Reset mid-HOLD: Q_out drops to 0 asynchronously; any pending trigger is lost.
- Outputs Q_out, busy and pending are registered (no combinational path from trig_in). miss is registered, one cycle after the dropped trigger.

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2) and the default TICK_DIV for 10 ms at 100 MHz.
- One sub-module: tick_gen.
  - Parameterised divider with a synchronous clear input and a tick output.
  - Reusable by other timed blocks in place of an ad-hoc pulse generator.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, RETRIGGER=1 unless noted):
- Single pulse on trig_in at cycle 10 -> Q_out high cycles 11..22 (12 cycles), busy high cycles 11..30 (8 gap cycles), then IDLE.
- Retrigger at cycle 16 during HOLD -> Q_out stays high until cycle 28 (12 cycles from the retrigger); pending stays 0.
- RETRIGGER=0: triggers at cycles 14 and 15 -> pending=1 from cycle 15, miss pulse at cycle 16. After the gap ends, a second 12-cycle HOLD; pending clears on HOLD entry.
- Trigger during GAP at cycle 25 -> pending set; gap completes; HOLD re-entered at cycle 31 with no extra latency.
- GAP_TICKS=0 with a pending trigger -> Q_out never drops between the two holds (24 contiguous high cycles).
- reset driven low mid-HOLD with pending set -> Q_out, busy and pending all 0 immediately. After release, the block is idle and responds normally to the next trigger.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
// State encoding, default tick divider and a small helper.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // 10 ms tick from a 100 MHz clock
  localparam int DEF_TICK_DIV = 1_000_000;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger request in, stretched pulse and status out.
// master drives the trigger, slave is the stretcher.
interface pulse_stretcher_if;

  logic trig_in;
  logic Q_out;
  logic busy;
  logic pending;
  logic miss;

  modport master (
    output trig_in,
    input  Q_out,
    input  busy,
    input  pending,
    input  miss
  );

  modport slave (
    input  trig_in,
    output Q_out,
    output busy,
    output pending,
    output miss
  );

endinterface

// File: rtl/pulse_stretcher_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Synchronous clear restarts the count so timed intervals are exact.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into fixed-length pulses
// followed by a mandatory low gap, with a one-deep trigger queue.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int HOLD_TICKS = 10,
  parameter int GAP_TICKS  = 5,
  parameter int RETRIGGER  = 1
) (
  input logic              clk,
  input logic              reset,
  pulse_stretcher_if.slave bus
);

  localparam int TW =
    $clog2(max_int(HOLD_TICKS, GAP_TICKS) + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam bit RETRIG = (RETRIGGER != 0);
  localparam bit HAS_GAP = (GAP_TICKS > 0);

  state_e        r_state;
  logic [TW-1:0] r_tcnt;
  logic          r_q;
  logic          r_busy;
  logic          r_pend;
  logic          r_miss;

  logic   w_tick;
  logic   w_trig;
  logic   w_in_hold;
  logic   w_in_gap;
  logic   w_restart;
  logic   w_queue;
  logic   w_pend;
  logic   w_hold_end;
  logic   w_gap_end;
  logic   w_clr;
  logic   w_pend_nx;
  state_e w_next;

  assign w_trig    = bus.trig_in;
  assign w_in_hold = (r_state == ST_HOLD);
  assign w_in_gap  = (r_state == ST_GAP);

  assign w_restart = w_in_hold && w_trig && RETRIG;
  assign w_queue   = w_trig &&
                     (w_in_gap || (w_in_hold && !RETRIG));
  // a trigger on the last cycle is queued before the exit
  assign w_pend    = r_pend || w_queue;

  assign w_hold_end = w_in_hold && w_tick &&
                      (r_tcnt == HOLD_LAST);
  assign w_gap_end  = w_in_gap && w_tick &&
                      (r_tcnt == GAP_LAST);

  always_comb begin
    w_next    = r_state;
    w_pend_nx = w_pend;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        w_pend_nx = 1'b0;
        if (w_trig) w_next = ST_HOLD;
      end
      w_in_hold: begin
        if (w_restart) begin
          w_next = ST_HOLD;
        end else if (w_hold_end) begin
          if (HAS_GAP) begin
            w_next = ST_GAP;
          end else if (w_pend) begin
            w_next    = ST_HOLD;
            w_pend_nx = 1'b0;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      w_in_gap: begin
        if (w_gap_end) begin
          if (w_pend) begin
            w_next    = ST_HOLD;
            w_pend_nx = 1'b0;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next    = ST_IDLE;
        w_pend_nx = 1'b0;
      end
    endcase
  end

  assign w_clr = (r_state == ST_IDLE) || (w_next != r_state) ||
                 w_restart || w_hold_end || w_gap_end;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_nx;
      r_miss  <= w_queue && r_pend;
      r_q     <= (w_next == ST_HOLD);
      r_busy  <= (w_next != ST_IDLE);
      if (w_clr) begin
        r_tcnt <= '0;
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign bus.Q_out   = r_q;
  assign bus.busy    = r_busy;
  assign bus.pending = r_pend;
  assign bus.miss    = r_miss;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: three stretcher configurations driven by one
// trigger, compared each cycle against a cycle-countdown model.
module tb_pulse_stretcher;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic trig  = 1'b0;

  always #5 clk = ~clk;

  pulse_stretcher_if ifa ();
  pulse_stretcher_if ifb ();
  pulse_stretcher_if ifc ();

  assign ifa.trig_in = trig;
  assign ifb.trig_in = trig;
  assign ifc.trig_in = trig;

  pulse_stretcher #(
    .TICK_DIV(D), .HOLD_TICKS(3), .GAP_TICKS(2), .RETRIGGER(1)
  ) u_a (.clk(clk), .reset(reset), .bus(ifa));

  pulse_stretcher #(
    .TICK_DIV(D), .HOLD_TICKS(3), .GAP_TICKS(2), .RETRIGGER(0)
  ) u_b (.clk(clk), .reset(reset), .bus(ifb));

  pulse_stretcher #(
    .TICK_DIV(D), .HOLD_TICKS(3), .GAP_TICKS(0), .RETRIGGER(0)
  ) u_c (.clk(clk), .reset(reset), .bus(ifc));

  logic oq [3];
  logic ob [3];
  logic op [3];
  logic om [3];

  assign oq[0] = ifa.Q_out;
  assign ob[0] = ifa.busy;
  assign op[0] = ifa.pending;
  assign om[0] = ifa.miss;
  assign oq[1] = ifb.Q_out;
  assign ob[1] = ifb.busy;
  assign op[1] = ifb.pending;
  assign om[1] = ifb.miss;
  assign oq[2] = ifc.Q_out;
  assign ob[2] = ifc.busy;
  assign op[2] = ifc.pending;
  assign om[2] = ifc.miss;

  // mode: 0 idle, 1 output high, 2 forced low; rem = cycles left
  typedef struct {
    int st;
    int rem;
    bit pend;
    bit miss;
  } mdl_t;

  mdl_t m [3];
  int   ph [3] = '{3, 3, 3};
  int   pg [3] = '{2, 2, 0};
  int   pr [3] = '{1, 0, 0};

  int nvec  = 0;
  int nfail = 0;

  function automatic mdl_t mreset();
    mdl_t s;
    s.st   = 0;
    s.rem  = 0;
    s.pend = 1'b0;
    s.miss = 1'b0;
    return s;
  endfunction

  function automatic mdl_t mstep(
    input mdl_t s, input bit t,
    input int h, input int g, input int r
  );
    mdl_t n = s;
    n.miss = 1'b0;
    if (s.st == 0) begin
      if (t) begin
        n.st  = 1;
        n.rem = h * D;
      end
    end else if (s.st == 1 && t && r != 0) begin
      n.rem = h * D;
    end else begin
      if (t) begin
        if (s.pend) n.miss = 1'b1;
        else n.pend = 1'b1;
      end
      if (s.rem > 1) begin
        n.rem = s.rem - 1;
      end else if (s.st == 1 && g > 0) begin
        n.st  = 2;
        n.rem = g * D;
      end else if (n.pend) begin
        n.st   = 1;
        n.rem  = h * D;
        n.pend = 1'b0;
      end else begin
        n.st = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(
    input string tag, input int i, input logic obs, input logic exp
  );
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] observed=%b expected=%b t=%0t",
             tag, i, obs, exp, $time);
    end
  endtask

  task automatic chk_int(
    input string tag, input int obs, input int exp
  );
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("Q_out", i, oq[i], logic'(m[i].st == 1));
      chk("busy", i, ob[i], logic'(m[i].st != 0));
      chk("pending", i, op[i], logic'(m[i].pend));
      chk("miss", i, om[i], logic'(m[i].miss));
    end
  endtask

  // called just after a falling edge
  task automatic step(input bit t);
    trig = t;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], t, ph[i], pg[i], pr[i]);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    trig  = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m[i] = mreset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  int qa, ba, qb, mb, mc, ma, run, best, prob;

  initial begin
    for (int i = 0; i < 3; i++) m[i] = mreset();
    #1 reset = 1'b0;
    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0);

    // single pulse
    qa = 0; ba = 0;
    for (int k = 0; k < 35; k++) begin
      step(k == 0);
      qa += int'(oq[0]);
      ba += int'(ob[0]);
    end
    chk_int("single_q_len", qa, 12);
    chk_int("single_busy_len", ba, 20);

    // second trigger six cycles into the hold
    qa = 0; qb = 0; run = 0; best = 0;
    for (int k = 0; k < 50; k++) begin
      step(k == 0 || k == 6);
      qa += int'(oq[0]);
      qb += int'(oq[1]);
      run = oq[2] ? run + 1 : 0;
      if (run > best) best = run;
    end
    chk_int("retrig_q_len", qa, 18);
    chk_int("queued_q_len", qb, 24);
    chk_int("nogap_contig", best, 24);

    // queue overflow
    ma = 0; mb = 0; mc = 0;
    for (int k = 0; k < 50; k++) begin
      step(k == 0 || k == 4 || k == 5);
      ma += int'(om[0]);
      mb += int'(om[1]);
      mc += int'(om[2]);
    end
    chk_int("miss_cnt_a", ma, 0);
    chk_int("miss_cnt_b", mb, 1);
    chk_int("miss_cnt_c", mc, 1);

    // reset mid-hold with a queued trigger
    for (int k = 0; k < 6; k++) step(k == 0 || k == 3);
    chk("pend_before_rst", 1, op[1], 1'b1);
    do_reset();
    for (int k = 0; k < 20; k++) step(k == 1);

    // randomized traffic with occasional resets
    prob = 10;
    for (int k = 0; k < 2000; k++) begin
      if (k % 100 == 0) begin
        case ($urandom_range(0, 4))
          0: prob = 0;
          1: prob = 2;
          2: prob = 10;
          3: prob = 50;
          default: prob = 95;
        endcase
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 99) < prob);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
